// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add signed multiplier datapath.
// Provides the default operand width and the command encoding.
// Command priority is Clr_Ld > ClrA > Sub > Add > Shift. HOLD means
// that no command is asserted.
package mult_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    CLR_LD,
    CLR_A,
    SUB,
    ADD,
    SHIFT,
    HOLD
  } cmd_e;

  // Collapse the one-hot-ish command strobes into a single operation.
  function automatic cmd_e decode_cmd(input logic clr_ld, input logic clr_a,
                                      input logic sub, input logic add,
                                      input logic shift);
    if (clr_ld)     return CLR_LD;
    else if (clr_a) return CLR_A;
    else if (sub)   return SUB;
    else if (add)   return ADD;
    else if (shift) return SHIFT;
    else            return HOLD;
  endfunction

endpackage

// File: rtl/addsub9.sv
// Signed add/subtract on W-bit operands (WIDTH+1 with sign extension).
// Ports:
//   a   - minuend / augend
//   b   - subtrahend / addend
//   sub - 1: sum = a - b, 0: sum = a + b
//   sum - W-bit result; carry beyond bit W-1 is discarded
module addsub9 #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] w_b_eff;
  logic [W-1:0] w_cin;

  // Subtraction is a + ~b + 1. The +1 enters as a zero-extended carry-in.
  assign w_b_eff = sub ? ~b : b;
  assign w_cin   = {{(W-1){1'b0}}, sub};
  assign sum     = a + w_b_eff + w_cin;

endmodule

// File: rtl/mult_datapath.sv
// Register datapath for an upstream-sequenced shift-add signed multiplier.
// The datapath holds the registers X (sign-extension bit), A (upper product
// half) and B (multiplier / lower product half).
// Ports:
//   Clk      - clock; all state changes on the rising edge
//   Reset_n  - asynchronous active-low reset; clears X, A and B
//   S        - switch operand (multiplicand for Add/Sub, multiplier for load)
//   Clr_Ld   - clear X and A, load B from S
//   ClrA     - clear X and A only
//   Add, Sub - {X,A} <= A +/- S (signed, WIDTH+1 bits)
//   Shift    - arithmetic right shift of X:A:B (X unchanged)
//   Aval     - register A
//   Bval     - register B
//   X        - register X
//   M        - B[0]
//   Product  - {A,B}
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [WIDTH-1:0]   S,
  input  logic               Clr_Ld,
  input  logic               ClrA,
  input  logic               Add,
  input  logic               Sub,
  input  logic               Shift,
  output logic [WIDTH-1:0]   Aval,
  output logic [WIDTH-1:0]   Bval,
  output logic               X,
  output logic               M,
  output logic [2*WIDTH-1:0] Product
);

  logic             r_x;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  cmd_e             w_cmd;
  logic [WIDTH:0]   w_sum;

  assign w_cmd = decode_cmd(Clr_Ld, ClrA, Sub, Add, Shift);

  // Both operands are sign-extended by one bit so that the result's top bit
  // is the correct new sign for X.
  addsub9 #(
    .W(WIDTH + 1)
  ) u_addsub (
    .a  ({r_a[WIDTH-1], r_a}),
    .b  ({S[WIDTH-1], S}),
    .sub(w_cmd == SUB),
    .sum(w_sum)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x <= 1'b0;
      r_a <= '0;
      r_b <= '0;
    end else begin
      case (w_cmd)
        CLR_LD: begin
          r_x <= 1'b0;
          r_a <= '0;
          r_b <= S;
        end
        CLR_A: begin
          r_x <= 1'b0;
          r_a <= '0;
        end
        SUB, ADD: begin
          r_x <= w_sum[WIDTH];
          r_a <= w_sum[WIDTH-1:0];
        end
        SHIFT: begin
          r_a <= {r_x, r_a[WIDTH-1:1]};
          r_b <= {r_a[0], r_b[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign Aval    = r_a;
  assign Bval    = r_b;
  assign X       = r_x;
  assign M       = r_b[0];
  assign Product = {r_a, r_b};

endmodule

// File: tb/tb_mult_datapath.sv
module tb_mult_datapath;

  logic        Clk;
  logic        Reset_n;
  logic [7:0]  S;
  logic        Clr_Ld, ClrA, Add, Sub, Shift;
  logic [7:0]  Aval, Bval;
  logic        X, M;
  logic [15:0] Product;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  mult_datapath #(.WIDTH(8)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .S      (S),
    .Clr_Ld (Clr_Ld),
    .ClrA   (ClrA),
    .Add    (Add),
    .Sub    (Sub),
    .Shift  (Shift),
    .Aval   (Aval),
    .Bval   (Bval),
    .X      (X),
    .M      (M),
    .Product(Product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cmds();
    Clr_Ld = 0; ClrA = 0; Add = 0; Sub = 0; Shift = 0;
  endtask

  // Apply one command set for one clock and sample 1 time unit after the edge.
  task automatic step(input logic cl, input logic ca, input logic ad,
                      input logic sb, input logic sh, input logic [7:0] s_v);
    S = s_v; Clr_Ld = cl; ClrA = ca; Add = ad; Sub = sb; Shift = sh;
    @(posedge Clk);
    #1;
    idle_cmds();
  endtask

  task automatic chk_state(input string tag, input logic [7:0] a_e,
                           input logic [7:0] b_e, input logic x_e);
    chk({tag, ".A"}, {8'h00, Aval}, {8'h00, a_e});
    chk({tag, ".B"}, {8'h00, Bval}, {8'h00, b_e});
    chk({tag, ".X"}, {15'h0, X}, {15'h0, x_e});
  endtask

  task automatic multiply(input logic [7:0] b_v, input logic [7:0] s_v);
    step(1, 0, 0, 0, 0, b_v);
    for (int i = 0; i < 7; i++) begin
      if (M) step(0, 0, 1, 0, 0, s_v);
      step(0, 0, 0, 0, 1, s_v);
    end
    if (M) step(0, 0, 0, 1, 0, s_v);
    step(0, 0, 0, 0, 1, s_v);
  endtask

  initial begin
    Reset_n = 1; S = 8'h00;
    idle_cmds();

    // Asynchronous reset mid-cycle, no clock edge in between
    @(posedge Clk);
    #3;
    Reset_n = 0;
    #1;
    chk_state("async_rst", 8'h00, 8'h00, 1'b0);
    chk("async_rst.M", {15'h0, M}, 16'h0000);
    chk("async_rst.P", Product, 16'h0000);
    @(negedge Clk);
    Reset_n = 1;

    // Load
    step(1, 0, 0, 0, 0, 8'h07);
    chk_state("load", 8'h00, 8'h07, 1'b0);
    chk("load.M", {15'h0, M}, 16'h0001);

    // Add sign, then shift
    step(0, 0, 1, 0, 0, 8'hC5);
    chk_state("add_c5", 8'hC5, 8'h07, 1'b1);
    step(0, 0, 0, 0, 1, 8'hC5);
    chk_state("shift_c5", 8'hE2, 8'h83, 1'b1);
    chk("shift_c5.B7", {15'h0, Bval[7]}, 16'h0001);

    // Subtract
    step(0, 1, 0, 0, 0, 8'h00);
    chk_state("clra", 8'h00, 8'h83, 1'b0);
    step(0, 0, 0, 1, 0, 8'h07);
    chk_state("sub_07", 8'hF9, 8'h83, 1'b1);
    step(0, 1, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 8'h05);
    chk_state("add_05", 8'h05, 8'h83, 1'b0);
    step(0, 0, 0, 1, 0, 8'h05);
    chk_state("sub_05", 8'h00, 8'h83, 1'b0);

    // Hold with no command
    step(0, 0, 0, 0, 0, 8'hAA);
    chk_state("hold", 8'h00, 8'h83, 1'b0);

    // Add+Sub together -> Sub
    step(0, 0, 1, 1, 0, 8'h03);
    chk_state("add_sub", 8'hFD, 8'h83, 1'b1);

    // Full multiplies
    multiply(8'h07, 8'hC5);
    chk("mul_7_m59", Product, 16'hFE63);
    multiply(8'hFF, 8'hFF);
    chk("mul_m1_m1", Product, 16'h0001);

    // Priority
    step(1, 0, 1, 0, 1, 8'h07);
    chk_state("prio_ld", 8'h00, 8'h07, 1'b0);
    step(0, 0, 1, 0, 1, 8'hC5);
    chk_state("prio_add", 8'hC5, 8'h07, 1'b1);

    // Reset in the middle of the 7 * -59 sequence, during step 4
    step(1, 0, 0, 0, 0, 8'h07);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, 8'hC5);
      step(0, 0, 0, 0, 1, 8'hC5);
    end
    chk_state("mid_step3", 8'hCC, 8'h60, 1'b1);
    S = 8'hC5; Shift = 1;
    #2;
    Reset_n = 0;
    #1;
    chk_state("mid_rst", 8'h00, 8'h00, 1'b0);
    idle_cmds();
    #2;
    Reset_n = 1;
    repeat (3) @(posedge Clk);
    #1;
    chk_state("post_rst_hold", 8'h00, 8'h00, 1'b0);
    chk("post_rst_hold.P", Product, 16'h0000);

    // First edge after release samples commands
    step(1, 0, 0, 0, 0, 8'h5A);
    chk_state("post_rst_load", 8'h00, 8'h5A, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
